sap_cpu_core: RTL



---
 rtl/sap_cpu_core.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sap_cpu_core.sv
// Multi-cycle accumulator CPU with on-chip program/data RAM.
// Two cycles per instruction: FETCH then EXEC; load/start only when idle.
module sap_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              halted,
  output logic              cf,
  output logic              zf,
  output logic [ADDR_W-1:0] pc
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IMM_W = DATA_W - OPC_W;

  if (DATA_W < OPC_W + ADDR_W) begin : g_bad_widths
    $error("sap_cpu_core: DATA_W must be >= OPC_W + ADDR_W");
  end

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              cf_q, cf_d;
  logic              zf_q, zf_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] ram_q [DEPTH];

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;

  assign opcode  = ir_q[DATA_W-1 -: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = DATA_W'(ir_q[IMM_W-1:0]);
  assign mem_rd  = ram_q[operand];
  assign sum     = {1'b0, a_q} + {1'b0, mem_rd};
  assign diff    = a_q - mem_rd;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    ir_d      = ir_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    out_d     = out_q;
    ov_d      = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = prog_addr;
    ram_wdata = prog_data;
    case (state_q)
      S_IDLE, S_HALT: begin
        ram_we = prog_we;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          a_d     = '0;
          cf_d    = 1'b0;
          zf_d    = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = ram_q[pc_q];
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LDA: a_d = mem_rd;
          OP_ADD: begin
            b_d  = mem_rd;
            a_d  = sum[DATA_W-1:0];
            cf_d = sum[DATA_W];
            zf_d = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            b_d  = mem_rd;
            a_d  = diff;
            cf_d = (a_q >= mem_rd);
            zf_d = (diff == '0);
          end
          OP_STA: begin
            ram_we    = 1'b1;
            ram_waddr = operand;
            ram_wdata = a_q;
          end
          OP_LDI: a_d = imm;
          OP_JMP: pc_d = operand;
          OP_JC:  if (cf_q) pc_d = operand;
          OP_JZ:  if (zf_q) pc_d = operand;
          OP_OUT: begin
            out_d = a_q;
            ov_d  = 1'b1;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    end
  end

  // B is architectural state with no debug port of its own.
  logic unused_b;
  assign unused_b = ^b_q;

  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign pc        = pc_q;

endmodule
